serial_add_ctrl: RTL and testbench

- Sequencing controller that adds two WIDTH-bit operands with a single internal full-adder cell, one bit per clock, LSB first.
- Sits in front of the ALU path wherever area matters more than latency.
- Valid/ready handshake on both input and output sides.
- Holds the result until the consumer takes it.

---
 rtl/serial_add_ctrl.sv | 163 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands with
//               a single full-adder cell, one bit per clock, LSB first, behind
//               valid/ready handshakes on both the operand and result sides.
//               The result is held until the consumer accepts it.
//               Optional feature macro: SERIAL_ADD_SUB_EN (adds in_sub, a-b).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  // Index is wide enough to hold WIDTH-1 for every legal WIDTH, including 1.
  localparam int                IDXW   = $clog2(WIDTH) + 1;
  localparam logic [IDXW-1:0]   c_last = IDXW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  c_one  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_bit_mask;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_sum_bit;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic [WIDTH-1:0] w_b_latch;
  logic             w_cin_latch;

  // One-hot mask selects the bit position being processed this cycle; using a
  // mask rather than a variable part-select keeps the index width decoupled
  // from the operand width.
  assign w_bit_mask  = c_one << r_idx;
  assign w_a_bit     = |(r_a & w_bit_mask);
  assign w_b_bit     = |(r_b & w_bit_mask);

  // The single full-adder cell shared by every bit position.
  assign w_sum_bit   = w_a_bit ^ w_b_bit ^ r_carry;
  assign w_carry_out = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));

  // Accumulator with the current bit overwritten, so stale bits from an
  // earlier operation can never leak into a new result.
  assign w_acc_next  = (r_acc & ~w_bit_mask) | (w_sum_bit ? w_bit_mask : '0);
  assign w_last      = (r_idx == c_last);

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1: invert B and force the carry at latch time.
  assign w_b_latch   = in_sub ? ~in_b : in_b;
  assign w_cin_latch = in_sub ? 1'b1  : in_cin;
`else
  assign w_b_latch   = in_b;
  assign w_cin_latch = in_cin;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

  // Control FSM plus serial datapath; handshake outputs are registered copies
  // of the state decode so they change together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= w_b_latch;
            r_carry    <= w_cin_latch;
            r_idx      <= '0;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_carry_out;
          if (w_last) begin
            // Publish the full word including the bit computed this cycle.
            r_sum       <= w_acc_next;
            r_cout      <= w_carry_out;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end

        ST_DONE: begin
          // Result stays parked until the consumer takes it; no new operands
          // are accepted in this state.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=4 and WIDTH=1).
//               Honours SERIAL_ADD_SUB_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [3:0] in_a, in_b, out_sum;
  logic       in_sub;

  logic       in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
  logic [0:0] in_a1, in_b1, out_sum1;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] last_sum;
  logic       last_cout;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    logic [3:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[10];
  int   nvec;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin, input logic sub);
    int r;
    logic [4:0] res;
    if (sub) begin
      r = int'(a) - int'(b);
      res[3:0] = 4'((r + 16) % 16);
      res[4]   = (a >= b);
    end else begin
      r = int'(a) + int'(b) + int'(cin);
      res[3:0] = 4'(r % 16);
      res[4]   = (r >= 16);
    end
    return res;
  endfunction

  // Full transaction on the WIDTH=4 instance with protocol and timing checks.
  task automatic apply_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic sub, input logic [3:0] es, input logic ec,
                          input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready_idle"}, int'(in_ready), 1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin; in_sub = ~sub & HAS_SUB;
    chk({tag, " busy_run"}, int'(busy), 1);
    chk({tag, " in_ready_run"}, int'(in_ready), 0);
    chk({tag, " sum_held_run"}, int'(out_sum), int'(last_sum));
    chk({tag, " cout_held_run"}, int'(out_cout), int'(last_cout));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " sum"}, int'(out_sum), int'(es));
    chk({tag, " cout"}, int'(out_cout), int'(ec));
    chk({tag, " busy_done"}, int'(busy), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " in_ready_after"}, int'(in_ready), 1);
    chk({tag, " out_valid_after"}, int'(out_valid), 0);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " sum_held_idle"}, int'(out_sum), int'(es));
    last_sum  = es;
    last_cout = ec;
  endtask

  initial begin
    logic [4:0] m;
    logic [3:0] ra, rb;
    logic       rc, rs;
    int         lat;

    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; out_ready1 = 0;
    last_sum = 0; last_cout = 0;

    // Table of directed vectors with hand-computed results.
    nvec = 0;
    vecs[nvec++] = '{a: 4'd5,  b: 4'd3,  cin: 1'b0, sub: 1'b0, s: 4'd8,  co: 1'b0};
    vecs[nvec++] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, sub: 1'b0, s: 4'd0,  co: 1'b1};
    vecs[nvec++] = '{a: 4'd7,  b: 4'd8,  cin: 1'b1, sub: 1'b0, s: 4'd0,  co: 1'b1};
    vecs[nvec++] = '{a: 4'd9,  b: 4'd6,  cin: 1'b0, sub: 1'b0, s: 4'd15, co: 1'b0};
    vecs[nvec++] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sub: 1'b0, s: 4'd15, co: 1'b1};
    vecs[nvec++] = '{a: 4'd10, b: 4'd3,  cin: 1'b1, sub: 1'b0, s: 4'd14, co: 1'b0};
    if (HAS_SUB) begin
      vecs[nvec++] = '{a: 4'd5, b: 4'd3, cin: 1'b0, sub: 1'b1, s: 4'd2,  co: 1'b1};
      vecs[nvec++] = '{a: 4'd3, b: 4'd5, cin: 1'b0, sub: 1'b1, s: 4'd14, co: 1'b0};
      vecs[nvec++] = '{a: 4'd3, b: 4'd5, cin: 1'b1, sub: 1'b1, s: 4'd14, co: 1'b0};
      vecs[nvec++] = '{a: 4'd7, b: 4'd7, cin: 1'b1, sub: 1'b1, s: 4'd0,  co: 1'b1};
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst out_sum", int'(out_sum), 0);
    chk("rst out_cout", int'(out_cout), 0);
    chk("rst w1 in_ready", int'(in_ready1), 1);
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++)
      apply_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
               vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

    // Hold the result 5+3=8 while the producer pushes new operands.
    @(negedge clk);
    in_a = 4'd5; in_b = 4'd3; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("hold latency", lat, 4);
    in_a = 4'd1; in_b = 4'd2; in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold out_sum", int'(out_sum), 8);
      chk("hold out_cout", int'(out_cout), 0);
      chk("hold in_ready", int'(in_ready), 0);
      chk("hold out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release in_ready", int'(in_ready), 1);
    chk("hold release out_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("hold not taken busy", int'(busy), 0);
    chk("hold not taken sum", int'(out_sum), 8);
    last_sum = 4'd8; last_cout = 1'b0;

    // Reset two cycles into RUN discards the partial result.
    @(negedge clk);
    in_a = 4'd5; in_b = 4'd3; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst out_sum", int'(out_sum), 0);
    chk("midrst in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = 4'd0; last_cout = 1'b0;
    apply_op(4'd9, 4'd6, 1'b0, 1'b0, 4'd15, 1'b0, "post_rst");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 1'($urandom_range(1));
      rs = HAS_SUB ? 1'($urandom_range(1)) : 1'b0;
      m  = model(ra, rb, rc, rs);
      apply_op(ra, rb, rc, rs, m[3:0], m[4], $sformatf("rnd%0d", i));
    end

    // WIDTH=1 instance: a single RUN cycle per operation.
    for (int i = 0; i < 8; i++) begin
      int exp;
      @(negedge clk);
      in_a1 = 1'(i); in_b1 = 1'(i >> 1); in_cin1 = 1'(i >> 2);
      exp = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
      in_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("w1 busy_run", int'(busy1), 1);
      chk("w1 out_valid_run", int'(out_valid1), 0);
      @(negedge clk);
      chk("w1 out_valid", int'(out_valid1), 1);
      chk("w1 out_sum", int'(out_sum1), exp % 2);
      chk("w1 out_cout", int'(out_cout1), exp / 2);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      chk("w1 in_ready_after", int'(in_ready1), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
